// File: rtl/apb_rr_arbiter.sv
// APB-programmable round-robin arbiter with per-requester enable, grant
// hold limit, preemption on limit expiry and a sticky timeout interrupt.
//
// Handshake: the APB side is zero-wait. A transfer completes in the cycle
// where psel_i & penable_i are both high (pready_o is high exactly then).
// Writes commit and prdata_o is loaded at the clock edge ending that cycle.
// Requesters use level requests; a grant stays asserted until the
// requester drops its request, is disabled, or reaches its hold limit.
module apb_rr_arbiter #(
    parameter int NUM_REQ = 8,
    parameter int ID_W    = 3
) (
    input  logic               pclk_i,
    input  logic               prst_i,
    input  logic               psel_i,
    input  logic               penable_i,
    input  logic               pwrite_i,
    input  logic [7:0]         paddr_i,
    input  logic [7:0]         pwdata_i,
    output logic [7:0]         prdata_o,
    output logic               pready_o,
    output logic               pslverr_o,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    gnt_id_o,
    output logic               gnt_valid_o,
    output logic               timeout_irq_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [7:0] ADDR_EN     = 8'h10;
    localparam logic [7:0] ADDR_TOFLAG = 8'h11;
    localparam logic [7:0] ADDR_STATUS = 8'h12;

    // Architectural registers
    logic [7:0]         r_limit [NUM_REQ];
    logic [NUM_REQ-1:0] r_en;
    logic [NUM_REQ-1:0] r_toflag;
    logic [ID_W-1:0]    r_last_owner;
    logic [7:0]         r_cnt;
    state_t             r_state;

    // Registered outputs; r_gnt_id doubles as the current owner while granted
    logic [NUM_REQ-1:0] r_gnt;
    logic [ID_W-1:0]    r_gnt_id;
    logic               r_gnt_valid;
    logic               r_irq;
    logic [7:0]         r_prdata;

    // Combinational signals
    logic               w_access;
    logic               w_addr_limit;
    logic               w_addr_valid;
    logic               w_err;
    logic               w_wr;
    logic               w_rd;
    logic [7:0]         w_rdata;
    logic [7:0]         w_status;
    logic [NUM_REQ-1:0] w_eff;
    logic               w_found;
    logic [ID_W-1:0]    w_sel;
    logic [7:0]         w_owner_limit;
    state_t             w_state_nxt;
    logic               w_grant_start;
    logic               w_release;
    logic               w_timeout;
    logic [NUM_REQ-1:0] w_to_set;
    logic [NUM_REQ-1:0] w_to_clr;
    logic [NUM_REQ-1:0] w_toflag_nxt;

    function automatic logic [NUM_REQ-1:0] f_onehot(input logic [ID_W-1:0] id);
        logic [NUM_REQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    // ---------------- APB decode ----------------
    assign w_access     = psel_i & penable_i;
    assign w_addr_limit = (paddr_i < 8'(NUM_REQ));
    assign w_addr_valid = w_addr_limit | (paddr_i == ADDR_EN) |
                          (paddr_i == ADDR_TOFLAG) | (paddr_i == ADDR_STATUS);
    // STATUS is read-only, so a write to it is an error like a bad address
    assign w_err        = w_access & (~w_addr_valid | (pwrite_i & (paddr_i == ADDR_STATUS)));
    assign w_wr         = w_access & pwrite_i & ~w_err;
    assign w_rd         = w_access & ~pwrite_i & ~w_err;

    assign pready_o  = w_access;
    assign pslverr_o = w_err;

    // STATUS layout: bit7 = grant valid, low bits = grant index
    always_comb begin
        w_status             = '0;
        w_status[ID_W-1:0]   = r_gnt_id;
        w_status[7]          = r_gnt_valid;
    end

    // Read data mux; returns zero on any erroring access
    always_comb begin
        w_rdata = 8'h00;
        if (!w_err) begin
            if (w_addr_limit) begin
                w_rdata = r_limit[paddr_i[ID_W-1:0]];
            end else begin
                case (paddr_i)
                    ADDR_EN:     w_rdata = 8'(r_en);
                    ADDR_TOFLAG: w_rdata = 8'(r_toflag);
                    ADDR_STATUS: w_rdata = w_status;
                    default:     w_rdata = 8'h00;
                endcase
            end
        end
    end

    // ---------------- Arbitration ----------------
    assign w_eff         = req_i & r_en;
    assign w_owner_limit = r_limit[r_gnt_id];

    // Round-robin search: first effective request after last_owner, wrapping
    always_comb begin
        int v_pos;
        logic [ID_W-1:0] v_idx;
        w_found = 1'b0;
        w_sel   = r_last_owner;
        v_pos   = 0;
        v_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            v_pos = (int'(r_last_owner) + k) % NUM_REQ;
            v_idx = v_pos[ID_W-1:0];
            if (!w_found && w_eff[v_idx]) begin
                w_found = 1'b1;
                w_sel   = v_idx;
            end
        end
    end

    // FSM next state. GAP arbitrates like IDLE so a handover costs one cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_grant_start = 1'b0;
        w_release     = 1'b0;
        w_timeout     = 1'b0;
        case (r_state)
            ST_IDLE, ST_GAP: begin
                if (w_found) begin
                    w_state_nxt   = ST_GRANT;
                    w_grant_start = 1'b1;
                end else begin
                    w_state_nxt   = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!w_eff[r_gnt_id]) begin
                    w_release   = 1'b1;
                    w_state_nxt = ST_GAP;
                end else if ((w_owner_limit != 8'h00) && (r_cnt == w_owner_limit)) begin
                    w_release   = 1'b1;
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_GAP;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Timeout flags: a set from the arbiter beats a software clear
    assign w_to_set     = w_timeout ? f_onehot(r_gnt_id) : '0;
    assign w_to_clr     = (w_wr && (paddr_i == ADDR_TOFLAG)) ? pwdata_i[NUM_REQ-1:0] : '0;
    assign w_toflag_nxt = (r_toflag & ~w_to_clr) | w_to_set;

    // FSM state register, grant outputs and hold counter
    always_ff @(posedge pclk_i or negedge prst_i) begin
        if (!prst_i) begin
            r_state      <= ST_IDLE;
            r_gnt        <= '0;
            r_gnt_id     <= '0;
            r_gnt_valid  <= 1'b0;
            r_cnt        <= 8'h00;
            r_last_owner <= ID_W'(NUM_REQ - 1);
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_start) begin
                r_gnt       <= f_onehot(w_sel);
                r_gnt_id    <= w_sel;
                r_gnt_valid <= 1'b1;
                r_cnt       <= 8'h01;
            end else if (w_release) begin
                r_gnt        <= '0;
                r_gnt_id     <= '0;
                r_gnt_valid  <= 1'b0;
                r_last_owner <= r_gnt_id;
            end else if ((r_state == ST_GRANT) && (r_cnt != 8'hFF)) begin
                r_cnt <= r_cnt + 8'h01;
            end
        end
    end

    // Software-visible registers, timeout flags, irq and read data
    always_ff @(posedge pclk_i or negedge prst_i) begin
        if (!prst_i) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_limit[i] <= 8'h00;
            end
            r_en     <= '0;
            r_toflag <= '0;
            r_irq    <= 1'b0;
            r_prdata <= 8'h00;
        end else begin
            if (w_wr && w_addr_limit) begin
                r_limit[paddr_i[ID_W-1:0]] <= pwdata_i;
            end
            if (w_wr && (paddr_i == ADDR_EN)) begin
                r_en <= pwdata_i[NUM_REQ-1:0];
            end
            r_toflag <= w_toflag_nxt;
            r_irq    <= |w_toflag_nxt;
            if (w_rd || w_err) begin
                r_prdata <= w_rdata;
            end
        end
    end

    assign prdata_o      = r_prdata;
    assign gnt_o         = r_gnt;
    assign gnt_id_o      = r_gnt_id;
    assign gnt_valid_o   = r_gnt_valid;
    assign timeout_irq_o = r_irq;

endmodule
